// File: rtl/alu_op_sequencer.sv
// Pipelined, back-pressured driver for the 32-bit combinational ALU.
// Registers requests onto the ALU and queues flag-masked results in a small FIFO.
module alu_op_sequencer #(
    parameter int DEPTH = 2,
    parameter int TAGW  = 4,
    parameter int CNTW  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_cmd,
    input  logic [31:0]     req_a,
    input  logic [31:0]     req_b,
    input  logic [TAGW-1:0] req_tag,
    output logic [31:0]     alu_operandA,
    output logic [31:0]     alu_operandB,
    output logic [2:0]      alu_command,
    input  logic [31:0]     alu_result,
    input  logic            alu_carryout,
    input  logic            alu_zero,
    input  logic            alu_overflow,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_result,
    output logic            rsp_carryout,
    output logic            rsp_zero,
    output logic            rsp_overflow,
    output logic [TAGW-1:0] rsp_tag,
    input  logic            clear_sticky,
    output logic            sticky_ovf,
    output logic [CNTW-1:0] op_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [31:0]     result;
        logic            carryout;
        logic            zero;
        logic            overflow;
        logic [TAGW-1:0] tag;
    } rsp_t;

    rsp_t            mem [DEPTH];
    rsp_t            entry;
    logic [TAGW-1:0] tag_q;
    logic            issue_v;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW:0]     count;
    logic [PW+1:0]   level;
    logic            accept;
    logic            push;
    logic            pop;
    logic            arith;

    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign push      = issue_v;
    assign accept    = req_valid & req_ready;

    // Occupancy once the in-flight op lands; keeps the FIFO from overflowing.
    assign level     = {1'b0, count} + (PW+2)'(issue_v) - (PW+2)'(pop);
    assign req_ready = level < (PW+2)'(DEPTH);

    // Only ADD, SUB and SLT produce meaningful carry/overflow.
    always_comb begin
        arith = 1'b0;
        case (alu_command)
            3'b000, 3'b001, 3'b011: arith = 1'b1;
            default:                arith = 1'b0;
        endcase
    end

    assign entry.result   = alu_result;
    assign entry.carryout = alu_carryout & arith;
    assign entry.zero     = alu_zero;
    assign entry.overflow = alu_overflow & arith;
    assign entry.tag      = tag_q;

    assign rsp_result   = mem[rd_ptr].result;
    assign rsp_carryout = mem[rd_ptr].carryout;
    assign rsp_zero     = mem[rd_ptr].zero;
    assign rsp_overflow = mem[rd_ptr].overflow;
    assign rsp_tag      = mem[rd_ptr].tag;

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_operandA <= '0;
            alu_operandB <= '0;
            alu_command  <= '0;
            tag_q        <= '0;
            issue_v      <= 1'b0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            sticky_ovf   <= 1'b0;
            op_count     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (accept) begin
                alu_operandA <= req_a;
                alu_operandB <= req_b;
                alu_command  <= req_cmd;
                tag_q        <= req_tag;
            end
            issue_v <= accept;
            if (push) begin
                mem[wr_ptr] <= entry;
                wr_ptr      <= wr_ptr + PW'(1);
                op_count    <= op_count + CNTW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
            // A new overflow outranks a same-cycle clear.
            if (push && entry.overflow) begin
                sticky_ovf <= 1'b1;
            end else if (clear_sticky) begin
                sticky_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Driver side of the 32-bit structural ALU interface: accepts operation requests over a valid/ready handshake and registers them onto the ALU's operandA/operandB/command inputs.
- Captures the ALU's combinational result and flags one cycle later into a small response FIFO, returned over a second valid/ready handshake.
- Sits between the lab-3 CPU control path, or a testbench master, and the ALU instance, so the combinational ALU gets a pipelined, back-pressured interface.
- Also keeps a sticky overflow flag and a completed-operation counter.

Parameters:
- DEPTH, 2, response FIFO entries (power of two, ≥2).
- TAGW, 4, width of request/response tag.
- CNTW, 16, width of completed-operation counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request ready.
- req_cmd  in  3  ALU command: 000 ADD, 001 SUB, 010 XOR, 011 SLT, 100 AND, 101 NAND, 110 NOR, 111 OR.
- req_a  in  32  operand A.
- req_b  in  32  operand B.
- req_tag  in  TAGW  opaque tag, returned unchanged.
- alu_operandA  out  32  to ALU operandA.
- alu_operandB  out  32  to ALU operandB.
- alu_command  out  3  to ALU command.
- alu_result  in  32  from ALU result.
- alu_carryout  in  1  from ALU carryout.
- alu_zero  in  1  from ALU zero.
- alu_overflow  in  1  from ALU overflow.
- rsp_valid  out  1  response valid (FIFO non-empty).
- rsp_ready  in  1  response ready.
- rsp_result  out  32  head result.
- rsp_carryout  out  1  head carryout (masked).
- rsp_zero  out  1  head zero.
- rsp_overflow  out  1  head overflow (masked).
- rsp_tag  out  TAGW  head tag.
- clear_sticky  in  1  clears sticky_ovf.
- sticky_ovf  out  1  set by any completed op with masked overflow = 1.
- op_count  out  CNTW  number of responses pushed into FIFO.

Behaviour:
- Reset, synchronous, active-high, applies on any edge with reset=1, including mid-operation:
  - alu_operandA = 0, alu_operandB = 0, alu_command = 000.
  - In-flight stage (issue_v) cleared.
  - FIFO emptied: rsp_valid = 0; rsp_* data = 0.
  - sticky_ovf = 0, op_count = 0.
  - req_ready = 1 in the first cycle after reset.
  - In-flight and buffered ops are discarded with no response.
- Stage 1 (issue):
  - On req_valid & req_ready at edge N: register req_a/req_b/req_cmd onto alu_* outputs and req_tag into an internal tag register; issue_v = 1.
  - alu_* outputs hold their last value when no request is accepted (no toggling to 0).
- Stage 2 (capture):
  - At edge N+1, if issue_v, push {alu_result, masked carryout, alu_zero, masked overflow, tag} into the FIFO.
  - rsp_valid rises after edge N+1. Latency is 2 cycles from accept to rsp_valid.
- Flag masking:
  - For cmd ∈ {010, 100, 101, 110, 111}, stored carryout = 0 and overflow = 0.
  - For 000/001/011, the ALU values pass through.
  - zero always passes through.
- Ready rule: req_ready = (fifo_count + issue_v − pop_this_cycle) < DEPTH.
  - pop_this_cycle = rsp_valid & rsp_ready.
  - Guarantees the FIFO never overflows; no combinational path from req_valid to req_ready.
- Response pop: on rsp_valid & rsp_ready the FIFO head advances. Simultaneous push and pop at full or empty is legal; count is unchanged when both occur.
- Throughput: 1 op/cycle sustained when rsp_ready is held high.
- FIFO: circular, rd/wr pointers wrap modulo DEPTH. Responses are in request order.
- sticky_ovf:
  - Set on the push cycle when masked overflow = 1.
  - clear_sticky clears it.
  - If set and clear occur in the same cycle, set wins.
- op_count: increments on each push, wraps at 2^CNTW. Not affected by pops.
- Held output stability: rsp_* and rsp_valid stay stable while rsp_valid & !rsp_ready.

Test Plan:
- Reset then single ADD: a=7, b=5, tag=3 accepted at cycle 0 -> rsp_valid at cycle 2; result=12, carryout=0, zero=0, overflow=0, tag=3; op_count=1.
- SUB overflow: a=0x80000000, b=1 -> result 0x7FFFFFFF, overflow=1, sticky_ovf=1. Then clear_sticky pulsed together with a second overflowing push -> sticky_ovf stays 1.
- Logic masking: XOR a=0xFFFFFFFF, b=0xFFFFFFFF -> result 0, zero=1, carryout=0, overflow=0. NAND a=0, b=0 -> 0xFFFFFFFF.
- Back-pressure: rsp_ready=0, 4 back-to-back requests -> exactly DEPTH=2 accepted, req_ready=0 from then on, rsp_* stable. Release rsp_ready -> remaining requests drain in order, tags 0,1,2,3.
- Streaming with rsp_ready=1: 8 SLT ops (a=−1, b=0 -> 1; a=5, b=2 -> 0, alternating) -> one response per cycle after 2-cycle latency, op_count=8.
- Reset mid-stream: assert reset with 2 buffered and 1 in flight -> next cycle rsp_valid=0, req_ready=1, op_count=0, sticky_ovf=0, alu_command=000.
